// File: rtl/board_pkg.sv
// Shared types for the board row renderer: cell word layout, 24-bit pixel colour,
// the 4-to-8 bit colour expansion and the row-fetch FSM states.
package board_pkg;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } rgb444_t;

  typedef struct packed {
    logic       occupied;
    logic [2:0] rsvd;
    rgb444_t    rgb;
  } cell_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef enum logic [1:0] {IDLE, REQ, READY} state_t;

  function automatic rgb24_t expand444(input rgb444_t c);
    rgb24_t o;
    o.r = {c.r, c.r};
    o.g = {c.g, c.g};
    o.b = {c.b, c.b};
    return o;
  endfunction

endpackage

// File: rtl/row_buffer_pingpong.sv
// Ping-pong pair of cell-row banks: the fetch side writes the back bank while the
// pixel side reads the front bank; swap exchanges their roles.
module row_buffer_pingpong import board_pkg::*; #(
  parameter int DEPTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  cell_t         wr_data,
  input  logic          swap,
  input  logic [AW-1:0] rd_addr,
  output cell_t         rd_data
);

  cell_t bank0 [DEPTH];
  cell_t bank1 [DEPTH];
  logic  front_sel;

  // front_sel==0 means bank0 is on screen and bank1 is being filled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_sel <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else begin
      if (wr_en && front_sel)  bank0[wr_addr] <= wr_data;
      if (wr_en && !front_sel) bank1[wr_addr] <= wr_data;
      if (swap) front_sel <= ~front_sel;
    end
  end

  assign rd_data = front_sel ? bank1[rd_addr] : bank0[rd_addr];

endmodule

// File: rtl/board_row_renderer.sv
// Board row renderer: maps VGA DrawX/DrawY onto the Tetris board and prefetches the
// next block row from board RAM into a ping-pong buffer while the current row is shown.
module board_row_renderer import board_pkg::*; #(
  parameter int          BOARD_W   = 10,
  parameter int          BOARD_H   = 20,
  parameter int          SQ        = 24,
  parameter int          BOARD_X0  = 200,
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_TOTAL   = 525,
  parameter logic [23:0] SIDE_RGB  = 24'h00007C,
  parameter logic [23:0] EMPTY_RGB = 24'h000000,
  parameter bit          GRID_EN   = 1'b1,
  parameter logic [23:0] GRID_RGB  = 24'h202020
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        cell_req,
  output logic [7:0]  cell_row,
  output logic [7:0]  cell_col,
  input  logic        cell_valid,
  input  logic [15:0] cell_data,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        fetch_late,
  output logic [15:0] late_count
);

  localparam int            SW       = $clog2(SQ);
  localparam int            AW       = $clog2(BOARD_W);
  localparam logic [9:0]    X_LO     = 10'(BOARD_X0);
  localparam logic [9:0]    X_HI     = 10'(BOARD_X0 + BOARD_W * SQ);
  localparam logic [9:0]    Y_HI     = 10'(BOARD_H * SQ);
  localparam logic [SW-1:0] SUB_LAST = SW'(SQ - 1);

  logic [9:0]    x_q, y_q;
  logic [SW-1:0] sub_x_q, sub_y_q, sub_x, sub_y;
  logic [7:0]    col_q, blk_row_q, col, blk_row;
  logic          y_changed, boundary;
  logic          fired_q, trig_frame, trig_row, trigger;
  state_t        state_q, state_d;
  logic [7:0]    target_q, target_d;
  logic [AW-1:0] k_q, k_d, rd_addr;
  logic          wr_en, swap, late;
  logic          in_board;
  cell_t         front;
  rgb24_t        pix;
  logic          rsvd_unused;

  // Position is tracked incrementally from coordinate changes so no divider is needed.
  always_comb begin
    y_changed = (DrawY != y_q);
    sub_y     = sub_y_q;
    blk_row   = blk_row_q;
    if (DrawY == '0) begin
      sub_y   = '0;
      blk_row = '0;
    end else if (y_changed) begin
      if (sub_y_q == SUB_LAST) begin
        sub_y   = '0;
        blk_row = blk_row_q + 8'd1;
      end else begin
        sub_y = sub_y_q + SW'(1);
      end
    end
    sub_x = sub_x_q;
    col   = col_q;
    if (DrawX == X_LO) begin
      sub_x = '0;
      col   = '0;
    end else if (DrawX != x_q) begin
      if (sub_x_q == SUB_LAST) begin
        sub_x = '0;
        col   = col_q + 8'd1;
      end else begin
        sub_x = sub_x_q + SW'(1);
      end
    end
  end

  assign boundary   = y_changed && ((DrawY == '0) || (sub_y_q == SUB_LAST));
  assign trig_frame = (DrawX == 10'(H_ACTIVE)) && (DrawY == 10'(V_TOTAL - 1));
  assign trig_row   = (DrawX == 10'(H_ACTIVE)) && (sub_y == SUB_LAST) &&
                      (blk_row < 8'(BOARD_H - 1));
  // fired_q only suppresses repeats within the line on which it was set
  assign trigger    = (trig_frame || trig_row) && !(fired_q && !y_changed);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    k_d      = k_q;
    wr_en    = 1'b0;
    swap     = 1'b0;
    late     = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          target_d = trig_frame ? 8'd0 : blk_row + 8'd1;
          k_d      = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (cell_valid) begin
          wr_en = 1'b1;
          if (k_q == AW'(BOARD_W - 1)) state_d = READY;
          else                         k_d     = k_q + AW'(1);
        end
        late = boundary;
      end
      READY: begin
        if (boundary) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      k_q      <= k_d;
    end
  end

  assign cell_req = (state_q == REQ);
  assign cell_row = target_q;
  assign cell_col = 8'(k_q);
  assign rd_addr  = (col < 8'(BOARD_W)) ? col[AW-1:0] : '0;

  row_buffer_pingpong #(.DEPTH(BOARD_W), .AW(AW)) u_rows (
    .clk     (Clk),
    .rst     (Reset),
    .wr_en   (wr_en),
    .wr_addr (k_q),
    .wr_data (cell_t'(cell_data)),
    .swap    (swap),
    .rd_addr (rd_addr),
    .rd_data (front)
  );

  assign rsvd_unused = ^front.rsvd;
  assign in_board    = (DrawX >= X_LO) && (DrawX < X_HI) &&
                       (DrawY < Y_HI) && (DrawY < 10'(V_ACTIVE));

  always_comb begin
    pix = rgb24_t'(SIDE_RGB);
    if (in_board) begin
      if (GRID_EN && (sub_x == '0 || sub_y == '0)) pix = rgb24_t'(GRID_RGB);
      else if (!front.occupied)                    pix = rgb24_t'(EMPTY_RGB);
      else                                         pix = expand444(front.rgb);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q        <= '0;
      y_q        <= '0;
      sub_x_q    <= '0;
      sub_y_q    <= '0;
      col_q      <= '0;
      blk_row_q  <= '0;
      fired_q    <= 1'b0;
      Red        <= '0;
      Green      <= '0;
      Blue       <= '0;
      fetch_late <= 1'b0;
      late_count <= '0;
    end else begin
      x_q        <= DrawX;
      y_q        <= DrawY;
      sub_x_q    <= sub_x;
      sub_y_q    <= sub_y;
      col_q      <= col;
      blk_row_q  <= blk_row;
      fired_q    <= (fired_q && !y_changed) || trig_frame || trig_row;
      Red        <= pix.r;
      Green      <= pix.g;
      Blue       <= pix.b;
      fetch_late <= late;
      if (late && late_count != 16'hFFFF) late_count <= late_count + 16'd1;
    end
  end

endmodule
